// File: rtl/vip_gauss_pkg.sv
// Shared constants for the 5x5 binomial Gaussian filter: kernel taps, datapath widths, normalisation.
package vip_gauss_pkg;

    localparam int PIX_W      = 8;
    localparam int TAP_OUTER  = 1;
    localparam int TAP_MID    = 4;
    localparam int TAP_CTR    = 6;
    localparam int ROW_SUM_W  = 12;
    localparam int COL_SUM_W  = 16;
    localparam int NORM_SHIFT = 8;
    localparam int ROUND_BIAS = 128;
    localparam int CNT_W      = 3;
    localparam logic [CNT_W-1:0] BORDER_CNT = 3'd4;

    // Side-band state that travels with each window through the pipeline.
    typedef struct packed {
        logic             vsync;
        logic             href;
        logic             clken;
        logic             complete;
        logic [PIX_W-1:0] p33;
    } side_t;

endpackage

// File: rtl/vip_gauss5_tap_sum.sv
// Registered [1 4 6 4 1] weighted sum of five taps, shifts and adds only.
// Latency 1 cycle, no backpressure (new taps accepted every clock).
module vip_gauss5_tap_sum
    import vip_gauss_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  tap0,
    input  logic [IN_W-1:0]  tap1,
    input  logic [IN_W-1:0]  tap2,
    input  logic [IN_W-1:0]  tap3,
    input  logic [IN_W-1:0]  tap4,
    output logic [OUT_W-1:0] sum
);

    logic [OUT_W-1:0] t0, t1, t2, t3, t4;
    logic [OUT_W-1:0] sum_nxt;

    assign t0 = OUT_W'(tap0);
    assign t1 = OUT_W'(tap1);
    assign t2 = OUT_W'(tap2);
    assign t3 = OUT_W'(tap3);
    assign t4 = OUT_W'(tap4);

    // Centre weight 6 = 4 + 2.
    assign sum_nxt = t0
                   + (t1 << $clog2(TAP_MID))
                   + (t2 << $clog2(TAP_MID)) + (t2 << $clog2(TAP_CTR - TAP_MID))
                   + (t3 << $clog2(TAP_MID))
                   + t4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum <= '0;
        else     sum <= sum_nxt;
    end

endmodule

// File: rtl/vip_gaussian_filter_5x5_8bit.sv
// 5x5 separable binomial Gaussian smoothing of a streamed luma window, with border handling.
// Latency 3 cycles, no backpressure (accepts one window per clock).
module vip_gaussian_filter_5x5_8bit
    import vip_gauss_pkg::*;
#(
    parameter int BORDER_MODE = 0,
    parameter int ROUND_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] matrix_p11, input logic [7:0] matrix_p12, input logic [7:0] matrix_p13,
    input  logic [7:0] matrix_p14, input logic [7:0] matrix_p15,
    input  logic [7:0] matrix_p21, input logic [7:0] matrix_p22, input logic [7:0] matrix_p23,
    input  logic [7:0] matrix_p24, input logic [7:0] matrix_p25,
    input  logic [7:0] matrix_p31, input logic [7:0] matrix_p32, input logic [7:0] matrix_p33,
    input  logic [7:0] matrix_p34, input logic [7:0] matrix_p35,
    input  logic [7:0] matrix_p41, input logic [7:0] matrix_p42, input logic [7:0] matrix_p43,
    input  logic [7:0] matrix_p44, input logic [7:0] matrix_p45,
    input  logic [7:0] matrix_p51, input logic [7:0] matrix_p52, input logic [7:0] matrix_p53,
    input  logic [7:0] matrix_p54, input logic [7:0] matrix_p55,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_y
);

    localparam int NORM_W = COL_SUM_W + 1 - NORM_SHIFT;
    localparam int BIAS   = (ROUND_EN != 0) ? ROUND_BIAS : 0;

    logic [ROW_SUM_W-1:0] r1, r2, r3, r4, r5;
    logic [COL_SUM_W-1:0] col_sum;
    logic [COL_SUM_W:0]   biased;
    logic [NORM_W-1:0]    norm;
    logic [PIX_W-1:0]     y_filt, y_nxt;

    logic [CNT_W-1:0] col_cnt, row_cnt;
    logic             vsync_q, href_q, line_seen, armed;
    logic             vsync_rise, href_fall, complete_in;
    side_t            side_in, side_d1, side_d2;

    vip_gauss5_tap_sum #(.IN_W(PIX_W), .OUT_W(ROW_SUM_W)) u_row1 (
        .clk(clk), .rst(rst), .tap0(matrix_p11), .tap1(matrix_p12), .tap2(matrix_p13),
        .tap3(matrix_p14), .tap4(matrix_p15), .sum(r1));
    vip_gauss5_tap_sum #(.IN_W(PIX_W), .OUT_W(ROW_SUM_W)) u_row2 (
        .clk(clk), .rst(rst), .tap0(matrix_p21), .tap1(matrix_p22), .tap2(matrix_p23),
        .tap3(matrix_p24), .tap4(matrix_p25), .sum(r2));
    vip_gauss5_tap_sum #(.IN_W(PIX_W), .OUT_W(ROW_SUM_W)) u_row3 (
        .clk(clk), .rst(rst), .tap0(matrix_p31), .tap1(matrix_p32), .tap2(matrix_p33),
        .tap3(matrix_p34), .tap4(matrix_p35), .sum(r3));
    vip_gauss5_tap_sum #(.IN_W(PIX_W), .OUT_W(ROW_SUM_W)) u_row4 (
        .clk(clk), .rst(rst), .tap0(matrix_p41), .tap1(matrix_p42), .tap2(matrix_p43),
        .tap3(matrix_p44), .tap4(matrix_p45), .sum(r4));
    vip_gauss5_tap_sum #(.IN_W(PIX_W), .OUT_W(ROW_SUM_W)) u_row5 (
        .clk(clk), .rst(rst), .tap0(matrix_p51), .tap1(matrix_p52), .tap2(matrix_p53),
        .tap3(matrix_p54), .tap4(matrix_p55), .sum(r5));

    vip_gauss5_tap_sum #(.IN_W(ROW_SUM_W), .OUT_W(COL_SUM_W)) u_col (
        .clk(clk), .rst(rst), .tap0(r1), .tap1(r2), .tap2(r3), .tap3(r4), .tap4(r5),
        .sum(col_sum));

    // Normalise by the kernel sum (256); the saturation guards against illegal windows only.
    assign biased = {1'b0, col_sum} + (COL_SUM_W + 1)'(BIAS);
    assign norm   = NORM_W'(biased >> NORM_SHIFT);
    assign y_filt = (norm > NORM_W'(255)) ? 8'hFF : norm[PIX_W-1:0];

    // Window completeness, judged on the incoming stream with pre-increment counts.
    assign vsync_rise  = per_frame_vsync & ~vsync_q;
    assign href_fall   = href_q & ~per_frame_href;
    assign complete_in = armed && (col_cnt >= BORDER_CNT) && (row_cnt >= BORDER_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            line_seen <= 1'b0;
            armed     <= 1'b0;
        end else begin
            vsync_q <= per_frame_vsync;
            href_q  <= per_frame_href;
            if (!per_frame_href)
                col_cnt <= '0;
            else if (per_frame_clken && col_cnt < BORDER_CNT)
                col_cnt <= col_cnt + 3'd1;
            // A frame start outranks a simultaneous line end.
            if (vsync_rise)
                row_cnt <= '0;
            else if (href_fall && line_seen && row_cnt < BORDER_CNT)
                row_cnt <= row_cnt + 3'd1;
            if (!per_frame_href)
                line_seen <= 1'b0;
            else if (per_frame_clken)
                line_seen <= 1'b1;
            // Output stays in border state after reset until a full frame begins.
            if (vsync_rise)
                armed <= 1'b1;
        end
    end

    assign side_in = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken,
                       complete: complete_in, p33: matrix_p33};

    always_comb begin
        y_nxt = '0;
        if (side_d2.href) begin
            if (side_d2.complete)
                y_nxt = y_filt;
            else if (BORDER_MODE != 0)
                y_nxt = side_d2.p33;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_d1          <= '0;
            side_d2          <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_y       <= '0;
        end else begin
            side_d1          <= side_in;
            side_d2          <= side_d1;
            post_frame_vsync <= side_d2.vsync;
            post_frame_href  <= side_d2.href;
            post_frame_clken <= side_d2.clken;
            post_img_y       <= y_nxt;
        end
    end

endmodule

// File: tb/tb_vip_gaussian_filter_5x5_8bit.sv
// Bench: two filter configurations driven by one stream, checked against a frame-level reference model.
module tb_vip_gaussian_filter_5x5_8bit;

    logic clk = 1'b0;
    logic rst;
    logic vs, hr, ck;
    logic [7:0] p [1:5][1:5];
    logic       a_vs, a_hr, a_ck, b_vs, b_hr, b_ck;
    logic [7:0] a_y, b_y;
    logic [7:0] img [0:15][0:27];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       vs, hr, ck;
        logic [7:0] ya, yb;
    } exp_t;
    exp_t hist [$];

    int line_idx, beat_idx;
    bit armed, prev_vs, prev_hr, seen;

    always #5 clk = ~clk;

    // A: BORDER_MODE 0, rounding. B: centre passthrough at borders, truncation.
    vip_gaussian_filter_5x5_8bit #(.BORDER_MODE(0), .ROUND_EN(1)) dut_a (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
        .matrix_p11(p[1][1]), .matrix_p12(p[1][2]), .matrix_p13(p[1][3]), .matrix_p14(p[1][4]), .matrix_p15(p[1][5]),
        .matrix_p21(p[2][1]), .matrix_p22(p[2][2]), .matrix_p23(p[2][3]), .matrix_p24(p[2][4]), .matrix_p25(p[2][5]),
        .matrix_p31(p[3][1]), .matrix_p32(p[3][2]), .matrix_p33(p[3][3]), .matrix_p34(p[3][4]), .matrix_p35(p[3][5]),
        .matrix_p41(p[4][1]), .matrix_p42(p[4][2]), .matrix_p43(p[4][3]), .matrix_p44(p[4][4]), .matrix_p45(p[4][5]),
        .matrix_p51(p[5][1]), .matrix_p52(p[5][2]), .matrix_p53(p[5][3]), .matrix_p54(p[5][4]), .matrix_p55(p[5][5]),
        .post_frame_vsync(a_vs), .post_frame_href(a_hr), .post_frame_clken(a_ck), .post_img_y(a_y));

    vip_gaussian_filter_5x5_8bit #(.BORDER_MODE(1), .ROUND_EN(0)) dut_b (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
        .matrix_p11(p[1][1]), .matrix_p12(p[1][2]), .matrix_p13(p[1][3]), .matrix_p14(p[1][4]), .matrix_p15(p[1][5]),
        .matrix_p21(p[2][1]), .matrix_p22(p[2][2]), .matrix_p23(p[2][3]), .matrix_p24(p[2][4]), .matrix_p25(p[2][5]),
        .matrix_p31(p[3][1]), .matrix_p32(p[3][2]), .matrix_p33(p[3][3]), .matrix_p34(p[3][4]), .matrix_p35(p[3][5]),
        .matrix_p41(p[4][1]), .matrix_p42(p[4][2]), .matrix_p43(p[4][3]), .matrix_p44(p[4][4]), .matrix_p45(p[4][5]),
        .matrix_p51(p[5][1]), .matrix_p52(p[5][2]), .matrix_p53(p[5][3]), .matrix_p54(p[5][4]), .matrix_p55(p[5][5]),
        .post_frame_vsync(b_vs), .post_frame_href(b_hr), .post_frame_clken(b_ck), .post_img_y(b_y));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: 2-D binomial convolution written directly as a weighted sum.
    function automatic logic [7:0] gauss(input bit rnd);
        int w [5];
        int s;
        w = '{1, 4, 6, 4, 1};
        s = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s += w[r] * w[c] * int'(p[r+1][c+1]);
        s = (s + (rnd ? 128 : 0)) / 256;
        if (s > 255) s = 255;
        return s[7:0];
    endfunction

    task automatic model_reset();
        exp_t z;
        z.vs = 0; z.hr = 0; z.ck = 0; z.ya = 0; z.yb = 0;
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
        line_idx = 0; beat_idx = 0;
        armed = 0; prev_vs = 0; prev_hr = 0; seen = 0;
    endtask

    // Drive one input cycle and record what should emerge three edges later.
    task automatic beat(input logic v, input logic h, input logic c);
        exp_t e;
        bit cmp, fall;
        vs = v; hr = h; ck = c;
        cmp  = armed && (beat_idx >= 4) && (line_idx >= 4);
        e.vs = v; e.hr = h; e.ck = c;
        e.ya = !h ? 8'd0 : (cmp ? gauss(1'b1) : 8'd0);
        e.yb = !h ? 8'd0 : (cmp ? gauss(1'b0) : p[3][3]);
        hist.push_back(e);
        fall = prev_hr && !h;
        if (v && !prev_vs) begin
            line_idx = 0;
            armed = 1;
        end else if (fall && seen) begin
            line_idx++;
        end
        seen = h && (seen || c);
        beat_idx = !h ? 0 : beat_idx + (c ? 1 : 0);
        prev_vs = v; prev_hr = h;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = hist.pop_front();
        chk("post_vsync_a", {15'd0, a_vs}, {15'd0, e.vs});
        chk("post_href_a",  {15'd0, a_hr}, {15'd0, e.hr});
        chk("post_clken_a", {15'd0, a_ck}, {15'd0, e.ck});
        chk("y_a",          {8'd0, a_y},   {8'd0, e.ya});
        chk("post_vsync_b", {15'd0, b_vs}, {15'd0, e.vs});
        chk("post_href_b",  {15'd0, b_hr}, {15'd0, e.hr});
        chk("post_clken_b", {15'd0, b_ck}, {15'd0, e.ck});
        chk("y_b",          {8'd0, b_y},   {8'd0, e.yb});
    endtask

    task automatic set_win(input logic [7:0] bg, input int r, input int c, input logic [7:0] v);
        for (int i = 1; i <= 5; i++)
            for (int j = 1; j <= 5; j++)
                p[i][j] = bg;
        p[r][c] = v;
    endtask

    task automatic load_win(input int row, input int col);
        for (int i = 1; i <= 5; i++)
            for (int j = 1; j <= 5; j++)
                p[i][j] = img[row + i - 1][col + j - 1];
    endtask

    task automatic fill_img(input bit rnd, input logic [7:0] v);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 28; j++)
                img[i][j] = rnd ? 8'($urandom) : v;
    endtask

    // One strobed window held for two more cycles, then explicit constant checks.
    task automatic probe(input string tag, input logic [7:0] ya, input logic [7:0] yb);
        beat(0, 1, 1); tick();
        beat(0, 1, 0); tick();
        beat(0, 1, 0); tick();
        chk({tag, "_a"}, {8'd0, a_y}, {8'd0, ya});
        chk({tag, "_b"}, {8'd0, b_y}, {8'd0, yb});
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_y_a",    {8'd0, a_y},   16'd0);
        chk("rst_async_y_b",    {8'd0, b_y},   16'd0);
        chk("rst_async_href_a", {15'd0, a_hr}, 16'd0);
        chk("rst_async_clken_b", {15'd0, b_ck}, 16'd0);
        vs = 0; hr = 0; ck = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic run_frame(input int w, input int h, input bit gaps, input int rst_row);
        beat(1, 0, 0); tick();
        beat(1, 0, 0); tick();
        beat(0, 0, 0); tick();
        for (int r = 0; r < h; r++) begin
            int col;
            col = 0;
            while (col < w) begin
                bit c;
                c = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                load_win(r, col);
                if (r == rst_row && col == 5) begin
                    mid_reset();
                    return;
                end
                beat(0, 1, c); tick();
                if (c) col++;
            end
            // Gap frames end with vsync rising on the href fall, and a stray clken in blanking.
            beat(gaps && (r == h - 1), 0, gaps); tick();
            beat(0, 0, 0); tick();
        end
        repeat (3) begin
            beat(0, 0, 0); tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vs = 0; hr = 0; ck = 0;
        set_win(8'd0, 3, 3, 8'd0);
        #1;
        chk("reset_y_a",     {8'd0, a_y},   16'd0);
        chk("reset_y_b",     {8'd0, b_y},   16'd0);
        chk("reset_vsync_a", {15'd0, a_vs}, 16'd0);
        chk("reset_clken_b", {15'd0, b_ck}, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Directed windows: four primed lines, then border and filtered probes on line 4.
        beat(1, 0, 0); tick();
        beat(0, 0, 0); tick();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++) begin
                beat(0, 1, 1); tick();
            end
            beat(0, 0, 0); tick();
        end
        beat(0, 1, 1); tick();
        beat(0, 1, 1); tick();
        set_win(8'd0, 3, 3, 8'd77);
        probe("border_beat2", 8'd0, 8'd77);
        set_win(8'd0, 3, 3, 8'd0);
        beat(0, 1, 1); tick();
        set_win(8'd0, 3, 3, 8'd77);
        probe("first_complete_beat4", 8'd11, 8'd10);
        set_win(8'd0, 3, 3, 8'd255);
        probe("impulse", 8'd36, 8'd35);
        set_win(8'd0, 1, 1, 8'd255);
        probe("corner_tap", 8'd1, 8'd0);
        set_win(8'd255, 3, 3, 8'd255);
        probe("full_scale", 8'd255, 8'd255);
        beat(0, 0, 0); tick();
        beat(0, 0, 0); tick();

        // Flat field 20x10.
        fill_img(1'b0, 8'd100);
        run_frame(20, 10, 1'b0, -1);

        // Random content with clken gaps, two consecutive frames.
        fill_img(1'b1, 8'd0);
        run_frame(22, 8, 1'b1, -1);
        run_frame(22, 8, 1'b1, -1);

        // Reset during row 6, then the same frame replayed from a fresh vsync.
        fill_img(1'b1, 8'd0);
        run_frame(16, 10, 1'b0, 6);
        run_frame(16, 10, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
